// File: rtl/mult_share_ctrl_pkg.sv
// Shared widths and FSM encoding for the time-shared multiplier controller.
package mult_share_ctrl_pkg;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/booth_multiplier.sv
// Combinational 16x16 signed radix-4 Booth multiplier producing a full 32-bit product.
module booth_multiplier
    import mult_share_ctrl_pkg::*;
(
    input  logic signed [DATA_W-1:0] A,
    input  logic signed [DATA_W-1:0] B,
    output logic signed [PROD_W-1:0] P
);
    localparam int NUM_PP = DATA_W / 2;

    logic [DATA_W:0]   b_ext;
    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] pp [NUM_PP];
    logic [PROD_W-1:0] sum;

    assign b_ext = {B, 1'b0};
    assign a_ext = {{(PROD_W-DATA_W){A[DATA_W-1]}}, A};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PP; gi++) begin : g_pp
            logic [PROD_W-1:0] mag;
            // Overlapping 3-bit windows of B select a digit in {-2,-1,0,+1,+2}.
            always_comb begin
                unique case (b_ext[2*gi+2 -: 3])
                    3'b001, 3'b010: mag = a_ext;
                    3'b011:         mag = a_ext << 1;
                    3'b100:         mag = -(a_ext << 1);
                    3'b101, 3'b110: mag = -a_ext;
                    default:        mag = '0;
                endcase
            end
            assign pp[gi] = mag << (2 * gi);
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            sum = sum + pp[i];
        end
    end

    assign P = sum;
endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    logic [ID_W-1:0] cand [NUM_REQ];
    logic            found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum = {1'b0, ptr} + (ID_W+1)'(gi);
            assign cand[gi] = (sum >= (ID_W+1)'(NUM_REQ))
                            ? ID_W'(sum - (ID_W+1)'(NUM_REQ))
                            : sum[ID_W-1:0];
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        grant     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[cand[k]]) begin
                found     = 1'b1;
                grant_idx = cand[k];
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end
endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one Booth multiplier among NUM_REQ requesters with round-robin
// grants and a back-pressured, requester-tagged result channel.
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ID_W-1:0]           res_id,
    output logic [PROD_W-1:0]         res_p,
    output logic                      busy
);
    state_t                    state_reg, state_next;
    logic [ID_W-1:0]           rr_ptr_reg;
    logic [NUM_REQ-1:0]        grant;
    logic [ID_W-1:0]           grant_idx;
    logic signed [DATA_W-1:0]  a_q, b_q;
    logic [ID_W-1:0]           id_q;
    logic signed [PROD_W-1:0]  prod;
    logic                      accept;
    logic [DATA_W-1:0]         a_arr [NUM_REQ];
    logic [DATA_W-1:0]         b_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[DATA_W*gi +: DATA_W];
            assign b_arr[gi] = req_b[DATA_W*gi +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    booth_multiplier u_mul (
        .A (a_q),
        .B (b_q),
        .P (prod)
    );

    // Grants are only offered while idle and never while reset is held.
    assign req_ready = (state_reg == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign busy      = (state_reg != IDLE);

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    state_next = DONE;
            DONE:    if (res_valid && res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            res_valid  <= 1'b0;
            res_p      <= '0;
            res_id     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_q        <= a_arr[grant_idx];
                b_q        <= b_arr[grant_idx];
                id_q       <= grant_idx;
                rr_ptr_reg <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
            end
            if (state_reg == CALC) begin
                res_valid <= 1'b1;
                res_p     <= prod;
                res_id    <= id_q;
            end else if (state_reg == DONE && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mult_share_ctrl.sv
// Scoreboard bench for mult_share_ctrl: a transaction-level model predicts grants
// and products, a separate monitor checks every presented result.
module tb_mult_share_ctrl;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [16*N-1:0] req_a, req_b;
    logic [N-1:0]    req_ready;
    logic            res_valid, res_ready;
    logic [1:0]      res_id;
    logic [31:0]     res_p;
    logic            busy;

    typedef struct {
        int id;
        int p;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   m_busy   = 1'b0;
    int   m_ptr    = 0;
    int   m_acc    = 0;

    mult_share_ctrl #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_p     (res_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: grant = first pending requester from the pointer, result
    // two cycles after accept, free again once the result has been taken.
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        int           w;
        bit           exp_busy, exp_valid;
        shortint      sa, sb;
        exp_t         e;
        exp_ready = '0;
        w         = -1;
        exp_busy  = m_busy && !rst;
        exp_valid = exp_busy && (cyc >= m_acc + 2);
        if (!rst && !m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
        end
        if (w >= 0) exp_ready[w] = 1'b1;
        chk("req_ready", longint'(req_ready), longint'(exp_ready));
        chk("busy", longint'(busy), longint'(exp_busy));
        chk("res_valid", longint'(res_valid), longint'(exp_valid));
        if (rst) begin
            chk("rst_res_p", longint'(res_p), 0);
            chk("rst_res_id", longint'(res_id), 0);
            exp_q.delete();
            m_busy = 1'b0;
            m_ptr  = 0;
        end else if (w >= 0) begin
            sa   = req_a[16*w +: 16];
            sb   = req_b[16*w +: 16];
            e.id = w;
            e.p  = int'(sa) * int'(sb);
            exp_q.push_back(e);
            $display("accept id=%0d a=%0d b=%0d expect p=%0d", w, sa, sb, e.p);
            m_busy = 1'b1;
            m_acc  = cyc;
            m_ptr  = (w + 1) % N;
        end else if (exp_valid && res_ready) begin
            m_busy = 1'b0;
        end
    end

    // Monitor: every presented result must match the oldest expected one.
    always @(posedge clk) begin
        #3;
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                chk("res_unexpected_id", longint'(res_id), -1);
            end else begin
                chk("res_id", longint'(res_id), longint'(exp_q[0].id));
                chk("res_p", longint'($signed(res_p)), longint'(exp_q[0].p));
                if (res_ready) begin
                    $display("result id=%0d p=%0d", res_id, $signed(res_p));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic raise(input int i, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]     = 1'b1;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic wait_grant(input int i);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 60 && !got; t++) begin
            @(negedge clk);
            if (req_valid[i] && req_ready[i]) got = 1'b1;
        end
        chk("grant_wait", longint'(got), 1);
    endtask

    task automatic wait_idle();
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 60 && !idle; t++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        chk("idle_wait", longint'(idle), 1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] acc;
        int           got, last;
        logic [15:0]  ca [6];
        logic [15:0]  cb [6];
        ca = '{16'hFFF0, 16'hFF3A, 16'hFFFE, 16'h8000, 16'h7FFF, 16'h8000};
        cb = '{16'hFFC1, 16'h7D7B, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        step();

        // Reset mid-CALC discards the result; requester 1 is re-granted afterwards.
        raise(1, 16'd25, 16'd96);
        wait_grant(1);
        step();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        wait_grant(1);
        step();
        req_valid[1] = 1'b0;
        wait_idle();

        // Corner operands from requester 0.
        for (int k = 0; k < 6; k++) begin
            raise(0, ca[k], cb[k]);
            wait_grant(0);
            step();
            req_valid[0] = 1'b0;
            wait_idle();
        end

        // Fairness with all requesters pending from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) raise(i, 16'($urandom), 16'($urandom));
        step(); step();
        rst = 1'b0;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            got = -1;
            for (int t = 0; t < 20 && got < 0; t++) begin
                @(negedge clk);
                for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) got = i;
            end
            chk("rr_order", longint'(got), longint'(g % N));
            if (g > 0) chk("rr_gap", longint'(cyc - last), 3);
            last = cyc;
            step();
            if (got >= 0) raise(got, 16'($urandom), 16'($urandom));
        end
        req_valid = '0;
        wait_idle();

        // Back-pressure: result must hold for 10 cycles.
        res_ready = 1'b0;
        raise(2, 16'd3877, 16'd7062);
        wait_grant(2);
        step();
        req_valid[2] = 1'b0;
        repeat (12) step();
        res_ready = 1'b1;
        wait_idle();

        // Pointer wrap: after 3, pending 0 and 2 are served as 0 then 2.
        raise(3, 16'd100, 16'hFF9C);
        wait_grant(3);
        step();
        req_valid[3] = 1'b0;
        raise(0, 16'd7, 16'd9);
        raise(2, 16'hFFFF, 16'd1234);
        wait_grant(0);
        step();
        req_valid[0] = 1'b0;
        wait_grant(2);
        step();
        req_valid[2] = 1'b0;
        wait_idle();

        // Withdrawn request while busy gets neither grant nor result.
        raise(0, 16'd11, 16'd13);
        wait_grant(0);
        step();
        req_valid[0] = 1'b0;
        raise(2, 16'd5, 16'd5);
        step();
        req_valid[2] = 1'b0;
        wait_idle();
        repeat (4) step();

        // Randomized traffic with random back-pressure and occasional withdrawal.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            step();
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    raise(i, 16'($urandom), 16'($urandom));
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        req_valid = '0;
        res_ready = 1'b1;
        wait_idle();
        repeat (3) step();
        chk("scoreboard_empty", longint'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mult_share_ctrl.md
# mult_share_ctrl

Sequential arbiter/controller that time-shares one 16×16 signed `booth_multiplier` among `NUM_REQ` requesters in the DSP datapath. It accepts one operand pair at a time through a valid/ready handshake with round-robin fairness. It registers operands and product around the combinational multiplier and returns the 32-bit product tagged with the requester index on a back-pressured result channel.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, at least 2.
- `ID_W`, 2: width of `res_id`, equal to clog2(`NUM_REQ`).

Ports:
- `clk`, in, 1: the only clock; rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NUM_REQ`: bit i means requester i presents an operand pair.
- `req_a`, in, 16×`NUM_REQ`: signed operand A, flattened; requester i occupies [16i+15:16i].
- `req_b`, in, 16×`NUM_REQ`: signed operand B, flattened with the same layout.
- `req_ready`, out, `NUM_REQ`: one-hot grant/accept; the transfer happens in a cycle where `req_valid[i]` and `req_ready[i]` are both high.
- `res_valid`, out, 1: the result is available.
- `res_ready`, in, 1: the consumer accepts the result.
- `res_id`, out, `ID_W`: index of the requester that owns the result.
- `res_p`, out, 32: signed product A×B.
- `busy`, out, 1: high whenever state is not IDLE.

## Operation
- FSM has three states: IDLE, CALC, DONE. Reset state is IDLE.
- **IDLE**
  - Round-robin arbitration over `req_valid`. The search starts at `rr_ptr`, wraps modulo `NUM_REQ`, and the first set bit wins.
  - `req_ready` is combinational and is the one-hot winner. It is all-zero when no request is pending.
  - On the accept edge: latch `a_q`, `b_q` and `id_q` from the winner, set `rr_ptr` to winner+1 (wrapping), and go to CALC.
- **CALC**
  - `booth_multiplier` sees `A=a_q`, `B=b_q`.
  - At the end of the cycle, `res_p` takes P, `res_id` takes `id_q`, `res_valid` is set to 1, and the FSM goes to DONE.
- **DONE**
  - `res_valid`, `res_p` and `res_id` hold steady until `res_valid && res_ready`.
  - On that edge `res_valid` clears and the FSM goes to IDLE.
  - While `res_ready` stays low, the FSM stalls indefinitely.
- `req_ready` is 0 in CALC and DONE. Requesters must hold `req_valid` and their operands stable until accepted. A requester that drops `req_valid` before it is accepted gets no grant and no result.
- Arithmetic: two's complement, full-precision 32-bit product, no saturation and no rounding. −32768×−32768 = 0x40000000 fits without overflow.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that lost is guaranteed a grant within `NUM_REQ` transactions.
- `rr_ptr` changes only on an accept.
- Reset applied at any time, including mid-CALC or mid-DONE:
  - The in-flight result is discarded.
  - State goes to IDLE and `rr_ptr` to 0.
  - All registered outputs clear immediately.
  - `req_ready` is forced to 0 while `rst` is high.

## Timing
- Reset values: `req_ready`=0, `res_valid`=0, `res_p`=0, `res_id`=0, `busy`=0, `rr_ptr`=0.
- The accept happens in cycle C0 (IDLE). C1 is CALC. `res_valid` goes high at the start of C2, so latency is 2 cycles from the accept edge to valid data.
- With `res_ready` held high, the result is consumed in C2, C3 is IDLE, and the next accept can happen in C3. Peak throughput is one product per 3 cycles.
- `res_p` and `res_id` are registers and do not glitch. The combinational path runs only from `req_valid` to `req_ready`.
- `busy` goes high the cycle after an accept and low the cycle after the result is consumed.

## Structure
- Shared package/header holds: `DATA_W`=16, `PROD_W`=32, and the state encodings IDLE=2'd0, CALC=2'd1, DONE=2'd2.
- Instantiate the existing `booth_multiplier` (ports A, B, P) unchanged, driven from `a_q` and `b_q`.
- A natural sub-module is `rr_arbiter`:
  - Parameter `NUM_REQ`.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `grant` and `grant_idx`.
  - Purely combinational; the pointer register stays in the parent.

## Test plan
- **Reset behaviour:** assert `rst` mid-CALC with requester 1 holding a=25, b=96. Expect all outputs at 0 and no `res_valid` afterwards. After release, requester 1 is granted; 2 cycles later `res_p`=2400 and `res_id`=1.
- **Single requester, corner operands:** requester 0 sends a=−16,b=−63 → 1008; a=−198,b=32123 → −6360354; a=−2,b=32767 → −65534; a=−32768,b=−32768 → 1073741824; a=32767,b=32767 → 1073676289; a=−32768,b=32767 → −1073709056. Check each at accept+2 cycles.
- **Round-robin fairness:** all four `req_valid` held high from reset with `res_ready`=1. Grants must come in order 0,1,2,3,0, each 3 cycles apart, and `res_id` must match each grant.
- **Back-pressure:** hold `res_ready`=0 for 10 cycles after `res_valid` rises with a=3877, b=7062. `res_p`=27379374 must stay stable, all of `req_ready` must stay 0 and `busy` must stay 1. Release `res_ready` and expect IDLE in the next cycle.
- **Pointer wrap:** after a grant to requester 3, with requesters 0 and 2 pending, the next grant goes to 0 and then to 2.
- **Withdrawn request:** requester 2 raises `req_valid` for one cycle while the block is busy, then drops it. Expect no grant to 2 and no result with `res_id`=2.
